// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : alu_share_arb_pkg                                      |
// | Description : ALU opcode classes, full opcode encodings and default  |
// |               datapath width shared by the ALU arbiter slice.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_share_arb_pkg;

  // Default operand/result width (matches REG_BUS)
  localparam int ALU_XLEN_DEF = 64;

  // Opcode class field, aluop[3:2]
  localparam logic [1:0] ALU_CLS_ARTH  = 2'b00;
  localparam logic [1:0] ALU_CLS_LOGIC = 2'b01;
  localparam logic [1:0] ALU_CLS_SHIFT = 2'b10;
  localparam logic [1:0] ALU_CLS_COMP  = 2'b11;

  // Full opcodes: bit[0] = sub / shift-right, bit[1] = arithmetic shift / unsigned compare
  localparam logic [3:0] ALU_ADD  = {ALU_CLS_ARTH,  2'b00};
  localparam logic [3:0] ALU_SUB  = {ALU_CLS_ARTH,  2'b01};
  localparam logic [3:0] ALU_XOR  = {ALU_CLS_LOGIC, 2'b00};
  localparam logic [3:0] ALU_OR   = {ALU_CLS_LOGIC, 2'b01};
  localparam logic [3:0] ALU_AND  = {ALU_CLS_LOGIC, 2'b10};
  localparam logic [3:0] ALU_SLL  = {ALU_CLS_SHIFT, 2'b00};
  localparam logic [3:0] ALU_SRL  = {ALU_CLS_SHIFT, 2'b01};
  localparam logic [3:0] ALU_SRA  = {ALU_CLS_SHIFT, 2'b11};
  localparam logic [3:0] ALU_SLT  = {ALU_CLS_COMP,  2'b00};
  localparam logic [3:0] ALU_SLTU = {ALU_CLS_COMP,  2'b10};

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : alu_share_arb_if                                       |
// | Description : One requester's request + response channels toward    |
// |               the shared ALU arbiter.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface alu_share_arb_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       aluop;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic [TAG_W-1:0] tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  result;
  logic             eq;
  logic             less;
  logic [TAG_W-1:0] rsp_tag;

  // Requester side
  modport master (
    output req_valid, aluop, op1, op2, tag, rsp_ready,
    input  req_ready, rsp_valid, result, eq, less, rsp_tag
  );

  // Arbiter side
  modport slave (
    input  req_valid, aluop, op1, op2, tag, rsp_ready,
    output req_ready, rsp_valid, result, eq, less, rsp_tag
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arb_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arb2                                                |
// | Description : 2-way round-robin arbiter. Grant is combinational,    |
// |               one-hot or zero; on a tie the requester not granted   |
// |               most recently wins. No grant while rst is high.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible_i,
  output logic [1:0] grant_o
);

  // Index of the most recent winner; reset to 1 so requester 0 wins the first tie
  logic last_grant_q;
  logic last_grant_d;

  // Grant selection and last-winner bookkeeping
  always_comb begin
    grant_o      = 2'b00;
    last_grant_d = last_grant_q;
    if (!rst) begin
      unique case (eligible_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
      if (grant_o != 2'b00) last_grant_d = grant_o[1];
    end
  end

  // Remember the winner only when a grant actually happens
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_share_arb                                          |
// | Description : Shares one integer ALU between EX issue (r0) and the  |
// |               branch/AGU helper (r1). Round-robin issue, operands   |
// |               driven combinationally, ALU outputs captured into a   |
// |               one-entry response buffer per requester.              |
// | Options     : ALU_SHARE_ARB_STATS_EN adds grant/conflict counters.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN_DEF,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_arb_if.slave  r0,
  alu_share_arb_if.slave  r1,
  output logic [3:0]      alu_aluop,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_eq,
  input  logic            alu_less
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [31:0]     stat_grant0,
  output logic [31:0]     stat_grant1,
  output logic [31:0]     stat_conflict
`endif
);

  logic [1:0]       req_valid_w;
  logic [1:0]       rsp_ready_w;
  logic [1:0]       eligible_w;
  logic [1:0]       grant_w;

  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_valid_d;
  logic [XLEN-1:0]  result_q [2];
  logic [1:0]       eq_q;
  logic [1:0]       less_q;
  logic [TAG_W-1:0] tag_q    [2];

  assign req_valid_w = {r1.req_valid, r0.req_valid};
  assign rsp_ready_w = {r1.rsp_ready, r0.rsp_ready};

  // A buffer can take a new result when empty or being drained this cycle
  assign eligible_w = req_valid_w & (~rsp_valid_q | rsp_ready_w);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .eligible_i (eligible_w),
    .grant_o    (grant_w)
  );

  assign r0.req_ready = grant_w[0];
  assign r1.req_ready = grant_w[1];

  // Operand mux toward the shared ALU; idle bus is all zeros
  always_comb begin
    alu_aluop = 4'h0;
    alu_op1   = '0;
    alu_op2   = '0;
    if (grant_w[0]) begin
      alu_aluop = r0.aluop;
      alu_op1   = r0.op1;
      alu_op2   = r0.op2;
    end else if (grant_w[1]) begin
      alu_aluop = r1.aluop;
      alu_op1   = r1.op1;
      alu_op2   = r1.op2;
    end
  end

  // Buffer occupancy: fill on grant, otherwise empty when the requester drains
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    for (int i = 0; i < 2; i++) begin
      if (grant_w[i])          rsp_valid_d[i] = 1'b1;
      else if (rsp_ready_w[i]) rsp_valid_d[i] = 1'b0;
    end
  end

  // Response buffers: capture the ALU outputs and the winner's tag on a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 2'b00;
      eq_q        <= 2'b00;
      less_q      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < 2; i++) begin
        if (grant_w[i]) begin
          result_q[i] <= alu_result;
          eq_q[i]     <= alu_eq;
          less_q[i]   <= alu_less;
          tag_q[i]    <= (i == 0) ? r0.tag : r1.tag;
        end
      end
    end
  end

  assign r0.rsp_valid = rsp_valid_q[0];
  assign r0.result    = result_q[0];
  assign r0.eq        = eq_q[0];
  assign r0.less      = less_q[0];
  assign r0.rsp_tag   = tag_q[0];
  assign r1.rsp_valid = rsp_valid_q[1];
  assign r1.result    = result_q[1];
  assign r1.eq        = eq_q[1];
  assign r1.less      = less_q[1];
  assign r1.rsp_tag   = tag_q[1];

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [31:0] stat_grant0_q;
  logic [31:0] stat_grant1_q;
  logic [31:0] stat_conflict_q;

  // Free-running wrap-around usage counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (grant_w[0])         stat_grant0_q   <= stat_grant0_q + 32'd1;
      if (grant_w[1])         stat_grant1_q   <= stat_grant1_q + 32'd1;
      if (&req_valid_w)       stat_conflict_q <= stat_conflict_q + 32'd1;
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_share_arb                                       |
// | Description : Self-checking bench for alu_share_arb: directed cases |
// |               plus randomized traffic against a transaction model.  |
// | Options     : ALU_SHARE_ARB_STATS_EN also checks the counters.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam logic [3:0] OPS [10] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
                                      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arb_if #(.XLEN(64), .TAG_W(4)) r0_if ();
  alu_share_arb_if #(.XLEN(64), .TAG_W(4)) r1_if ();

  logic [3:0]  alu_aluop;
  logic [63:0] alu_op1, alu_op2, alu_result;
  logic        alu_eq, alu_less;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  // Stimulus per requester
  logic        in_v  [2];
  logic [3:0]  in_op [2];
  logic [63:0] in_a  [2];
  logic [63:0] in_b  [2];
  logic [3:0]  in_t  [2];
  logic        in_rr [2];

  assign r0_if.req_valid = in_v[0];
  assign r0_if.aluop     = in_op[0];
  assign r0_if.op1       = in_a[0];
  assign r0_if.op2       = in_b[0];
  assign r0_if.tag       = in_t[0];
  assign r0_if.rsp_ready = in_rr[0];
  assign r1_if.req_valid = in_v[1];
  assign r1_if.aluop     = in_op[1];
  assign r1_if.op1       = in_a[1];
  assign r1_if.op2       = in_b[1];
  assign r1_if.tag       = in_t[1];
  assign r1_if.rsp_ready = in_rr[1];

  alu_share_arb #(.XLEN(64), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .r0         (r0_if),
    .r1         (r1_if),
    .alu_aluop  (alu_aluop),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .alu_eq     (alu_eq),
    .alu_less   (alu_less)
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  // Behavioural ALU: returns {result, eq, less}
  function automatic logic [65:0] alu_ref(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] res;
    logic        lt;
    lt = op[1] ? (a < b) : ($signed(a) < $signed(b));
    case (op[3:2])
      2'b00:   res = op[0] ? a - b : a + b;
      2'b01:   res = (op[1:0] == 2'b01) ? (a | b) : (op[1:0] == 2'b10) ? (a & b) : (a ^ b);
      2'b10:   res = !op[0] ? (a << b[5:0]) :
                     op[1] ? 64'($signed(a) >>> b[5:0]) : (a >> b[5:0]);
      default: res = {63'd0, lt};
    endcase
    return {res, a == b, lt};
  endfunction

  always_comb {alu_result, alu_eq, alu_less} = alu_ref(alu_aluop, alu_op1, alu_op2);

  // Transaction-level model of the two response buffers
  bit          m_valid [2];
  logic [63:0] m_res   [2];
  logic        m_eq    [2];
  logic        m_less  [2];
  logic [3:0]  m_tag   [2];
  int          m_last;
  int unsigned m_g0, m_g1, m_conf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // One clock: check everything visible now, step the clock, advance the model
  task automatic tick();
    bit   elig [2];
    int   win;
    logic [65:0] r;
    #2;
    for (int i = 0; i < 2; i++)
      elig[i] = !rst && in_v[i] && (!m_valid[i] || in_rr[i]);
    if (elig[0] && elig[1]) win = 1 - m_last;
    else if (elig[0])       win = 0;
    else if (elig[1])       win = 1;
    else                    win = -1;

    check("r0_req_ready", r0_if.req_ready, win == 0);
    check("r1_req_ready", r1_if.req_ready, win == 1);
    if (win >= 0) check("alu_bus", {alu_aluop, alu_op1, alu_op2}, {in_op[win], in_a[win], in_b[win]});
    else          check("alu_bus_idle", {alu_aluop, alu_op1, alu_op2}, 0);
    check("r0_rsp_valid", r0_if.rsp_valid, m_valid[0]);
    check("r1_rsp_valid", r1_if.rsp_valid, m_valid[1]);
    if (m_valid[0]) check("r0_rsp", {r0_if.result, r0_if.eq, r0_if.less, r0_if.rsp_tag},
                          {m_res[0], m_eq[0], m_less[0], m_tag[0]});
    if (m_valid[1]) check("r1_rsp", {r1_if.result, r1_if.eq, r1_if.less, r1_if.rsp_tag},
                          {m_res[1], m_eq[1], m_less[1], m_tag[1]});
`ifdef ALU_SHARE_ARB_STATS_EN
    check("stats", {stat_grant0, stat_grant1, stat_conflict}, {m_g0, m_g1, m_conf});
`endif

    @(posedge clk);
    if (rst) begin
      m_valid = '{0, 0};
      m_last  = 1;
      m_g0 = 0; m_g1 = 0; m_conf = 0;
    end else begin
      if (in_v[0] && in_v[1]) m_conf++;
      for (int i = 0; i < 2; i++) begin
        if (win == i) begin
          r          = alu_ref(in_op[i], in_a[i], in_b[i]);
          m_res[i]   = r[65:2];
          m_eq[i]    = r[1];
          m_less[i]  = r[0];
          m_tag[i]   = in_t[i];
          m_valid[i] = 1'b1;
        end else if (in_rr[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (win >= 0) begin
        m_last = win;
        if (win == 0) m_g0++; else m_g1++;
      end
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    in_v[i] = v; in_op[i] = op; in_a[i] = a; in_b[i] = b; in_t[i] = t;
  endtask

  initial begin
    m_valid = '{0, 0};
    m_last  = 1;
    m_g0 = 0; m_g1 = 0; m_conf = 0;
    rst = 1'b1;
    set_req(0, 1'b1, ALU_ADD, 64'd1, 64'd2, 4'd1);
    set_req(1, 1'b1, ALU_ADD, 64'd3, 64'd4, 4'd2);
    in_rr = '{1'b0, 1'b0};
    @(posedge clk); #1;

    // Reset with requests pending: nothing may be granted
    tick();
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    set_req(1, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    check("rst_buf0", {r0_if.result, r0_if.eq, r0_if.less, r0_if.rsp_tag}, 0);
    check("rst_buf1", {r1_if.result, r1_if.eq, r1_if.less, r1_if.rsp_tag}, 0);

    // Tie right after reset: r0 first, then r1, then alternate
    set_req(0, 1'b1, ALU_SUB, 64'd10, 64'd3, 4'd5);
    set_req(1, 1'b1, ALU_XOR, 64'hF0, 64'hFF, 4'd6);
    in_rr = '{1'b1, 1'b1};
    tick();
    check("tie_r0_result", r0_if.result, 64'd7);
    tick();
    check("tie_r1_result", r1_if.result, 64'h0F);
    for (int k = 0; k < 4; k++) tick();
    set_req(0, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    set_req(1, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    tick();

    // Single issue with 1-cycle latency and empty-after-drain
    set_req(0, 1'b1, ALU_ADD, 64'd5, 64'd7, 4'd3);
    tick();
    set_req(0, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    check("single_rsp", {r0_if.rsp_valid, r0_if.result, r0_if.rsp_tag}, {1'b1, 64'd12, 4'd3});
    tick();
    tick();

    // Backpressure: r1 buffer full and not drained, r0 keeps issuing
    in_rr[1] = 1'b0;
    set_req(1, 1'b1, ALU_SLL, 64'd1, 64'd8, 4'd9);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, OPS[$urandom_range(9)], {$urandom, $urandom}, 64'($urandom_range(70)),
              4'($urandom));
      set_req(1, 1'b1, ALU_ADD, {$urandom, $urandom}, 64'd1, 4'd4);
      tick();
    end
    check("bp_r1_hold", r1_if.result, 64'd256);
    set_req(1, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    in_rr[1] = 1'b1;

    // Drain-and-refill on a full r0 buffer, no bubble
    check("dr_full", r0_if.rsp_valid, 1'b1);
    set_req(0, 1'b1, ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd7);
    tick();
    check("dr_refill", {r0_if.rsp_valid, r0_if.result, r0_if.less}, {1'b1, 64'd1, 1'b1});

    // Reset one cycle after a grant discards the response
    set_req(0, 1'b1, ALU_OR, 64'h1234, 64'h8000, 4'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    check("midrst_buf0", {r0_if.rsp_valid, r0_if.result, r0_if.rsp_tag}, 0);
    set_req(0, 1'b1, ALU_AND, 64'hFF, 64'h0F, 4'd1);
    set_req(1, 1'b1, ALU_SRA, 64'h8000_0000_0000_0000, 64'd4, 4'd2);
    tick();
    check("midrst_tie_r0", r0_if.rsp_valid, 1'b1);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(59) == 0);
      for (int i = 0; i < 2; i++) begin
        set_req(i, 1'($urandom_range(3) != 0), OPS[$urandom_range(9)],
                ($urandom_range(1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(8)),
                ($urandom_range(1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(8)),
                4'($urandom));
        in_rr[i] = 1'($urandom_range(2) != 0);
      end
      tick();
    end

    // Usage counters: 8 contended cycles after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_rr = '{1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, ALU_ADD, 64'(k), 64'd1, 4'(k));
      set_req(1, 1'b1, ALU_SUB, 64'(k), 64'd1, 4'(k));
      tick();
    end
`ifdef ALU_SHARE_ARB_STATS_EN
    check("stats_8cyc", {stat_grant0, stat_grant1, stat_conflict}, {32'd4, 32'd4, 32'd8});
`endif
    set_req(0, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    set_req(1, 1'b0, 4'h0, 64'd0, 64'd0, 4'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
